// File: rtl/reg_dump_pkg.sv
// Shared types and constants for the register-dump reader: FSM states,
// index width and the order of the CSR words appended after the GPRs.
package reg_dump_pkg;

  localparam int IDX_W     = 6;
  localparam int CSR_COUNT = 6;

  // Word order inside csr_in, word 0 in bits [31:0]
  localparam int CSR_MSTATUS = 0;
  localparam int CSR_MIE     = 1;
  localparam int CSR_MTVEC   = 2;
  localparam int CSR_MIP     = 3;
  localparam int CSR_MEPC    = 4;
  localparam int CSR_MCAUSE  = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SEND,
    ST_DONE
  } state_e;

endpackage

// File: rtl/reg_dump_reader_if.sv
// Valid/ready stream carrying dumped words; master is the reader, slave the sink.
interface reg_dump_reader_if;
  import reg_dump_pkg::*;

  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;

  modport master (output out_valid, output out_data, output out_idx, output out_last,
                  input  out_ready);
  modport slave  (input  out_valid, input  out_data, input  out_idx, input  out_last,
                  output out_ready);

endinterface

// File: rtl/reg_dump_reader.sv
// Walks the CPU debug read port x0..x(NUM_REGS-1) and streams each settled word out.
// Optional feature: define REG_DUMP_CSR_EN to append six CSR words from csr_in.
module reg_dump_reader
  import reg_dump_pkg::*;
#(
  parameter int NUM_REGS      = 32,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start,
  output logic [4:0]                 reg_sel,
  input  logic [31:0]                reg_data,
`ifdef REG_DUMP_CSR_EN
  input  logic [CSR_COUNT*32-1:0]    csr_in,
`endif
  reg_dump_reader_if.master          out_if,
  output logic                       busy,
  output logic                       done
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] NREGS_IDX = IDX_W'(NUM_REGS);
`ifdef REG_DUMP_CSR_EN
  localparam int LAST_INT = NUM_REGS + CSR_COUNT - 1;
`else
  localparam int LAST_INT = NUM_REGS - 1;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAST_INT);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [4:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [31:0]      data_q, data_d;
  logic [IDX_W-1:0] oidx_q, oidx_d;
  logic             last_q, last_d;
  logic [IDX_W-1:0] idx_next;
  logic [31:0]      src_word;

  assign idx_next = idx_q + IDX_W'(1);

`ifdef REG_DUMP_CSR_EN
  // Padded to eight entries so any 3-bit offset lands on a defined word
  logic [31:0]      csr_word [8];
  logic [IDX_W-1:0] csr_off;

  for (genvar gi = 0; gi < 8; gi++) begin : g_csr_word
    if (gi < CSR_COUNT) begin : g_used
      assign csr_word[gi] = csr_in[gi*32 +: 32];
    end else begin : g_pad
      assign csr_word[gi] = '0;
    end
  end

  assign csr_off = idx_q - NREGS_IDX;

  always_comb begin
    src_word = reg_data;
    if (idx_q >= NREGS_IDX) src_word = csr_word[csr_off[2:0]];
  end
`else
  assign src_word = reg_data;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    data_d  = data_q;
    oidx_d  = oidx_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d   = '0;
          sel_d   = '0;
          cnt_d   = CNT_LOAD;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_ONE) begin
          data_d  = src_word;
          oidx_d  = idx_q;
          last_d  = (idx_q == LAST_IDX);
          valid_d = 1'b1;
          state_d = ST_SEND;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_SEND: begin
        if (valid_q && out_if.out_ready) begin
          valid_d = 1'b0;
          if (last_q) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_next;
            // reg_sel parks on the last GPR while CSR words stream out
            if (idx_next < NREGS_IDX) sel_d = idx_next[4:0];
            cnt_d   = CNT_LOAD;
            state_d = ST_SETTLE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      oidx_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      oidx_q  <= oidx_d;
      last_q  <= last_d;
    end
  end

  assign reg_sel          = sel_q;
  assign out_if.out_valid = valid_q;
  assign out_if.out_data  = data_q;
  assign out_if.out_idx   = oidx_q;
  assign out_if.out_last  = last_q;
  assign busy             = (state_q != ST_IDLE);
  assign done             = (state_q == ST_DONE);

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench: a default instance against a 0x100+N register file and a
// four-register, three-cycle-settle instance against a glitching read port.
`timescale 1ns/1ps
module tb_reg_dump_reader;
  import reg_dump_pkg::*;

`ifdef REG_DUMP_CSR_EN
  localparam int N_MAIN  = 38;
  localparam int N_SMALL = 10;
`else
  localparam int N_MAIN  = 32;
  localparam int N_SMALL = 4;
`endif

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] data;
    logic        last;
    logic [4:0]  sel;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstn, start, start3;
  logic [4:0]  reg_sel, reg_sel3;
  logic [31:0] reg_data, reg_data3;
  logic        busy, done, busy3, done3;
  logic [4:0]  sel3_p1 = '0, sel3_p2 = '0;
  int          cyc = 0, done_cnt = 0;
  int          n_tests = 0, n_fail = 0;
  vec_t        vecs [N_MAIN];

  always #5 clk = ~clk;

  reg_dump_reader_if m_if ();
  reg_dump_reader_if s_if ();

`ifdef REG_DUMP_CSR_EN
  logic [191:0] csr_in;
  assign csr_in = {32'h8000_000B, 32'h8000_1234, 32'h0000_0888,
                   32'h0000_0080, 32'h0000_0008, 32'h0000_1800};
`endif

  reg_dump_reader dut (
    .clk(clk), .rstn(rstn), .start(start), .reg_sel(reg_sel), .reg_data(reg_data),
`ifdef REG_DUMP_CSR_EN
    .csr_in(csr_in),
`endif
    .out_if(m_if), .busy(busy), .done(done)
  );

  reg_dump_reader #(.NUM_REGS(4), .SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rstn(rstn), .start(start3), .reg_sel(reg_sel3), .reg_data(reg_data3),
`ifdef REG_DUMP_CSR_EN
    .csr_in(csr_in),
`endif
    .out_if(s_if), .busy(busy3), .done(done3)
  );

  // CPU register files; the small one returns junk for two cycles after reg_sel moves
  assign reg_data  = (reg_sel == 5'd0) ? 32'h0 : 32'h100 + {27'b0, reg_sel};
  assign reg_data3 = (reg_sel3 != sel3_p1 || reg_sel3 != sel3_p2) ? 32'hDEAD_BEEF :
                     (reg_sel3 == 5'd0) ? 32'h0 : 32'h200 + {27'b0, reg_sel3};

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    sel3_p1 <= reg_sel3;
    sel3_p2 <= sel3_p1;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  function automatic logic [31:0] csr_exp(input int k);
    case (k)
      CSR_MSTATUS: return 32'h0000_1800;
      CSR_MIE:     return 32'h0000_0008;
      CSR_MTVEC:   return 32'h0000_0080;
      CSR_MIP:     return 32'h0000_0888;
      CSR_MEPC:    return 32'h8000_1234;
      default:     return 32'h8000_000B;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(m_if.out_valid), 0);
    chk({tag, "_data"},  m_if.out_data, 0);
    chk({tag, "_idx"},   32'(m_if.out_idx), 0);
    chk({tag, "_last"},  32'(m_if.out_last), 0);
    chk({tag, "_sel"},   32'(reg_sel), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_done"},  32'(done), 0);
  endtask

  task automatic run_dump(input int stall_word, input int poke_word,
                          input int abort_word, input bit timing);
    int k;
    int done0;
    bit ok;
    done0 = done_cnt;
    m_if.out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = cyc;
    chk("start_sel", 32'(reg_sel), 0);
    chk("start_busy", 32'(busy), 1);
    for (int i = 0; i < N_MAIN; i++) begin
      ok = 1'b0;
      for (int w = 0; w < 20; w++) begin
        @(posedge clk); #1;
        if (m_if.out_valid) begin ok = 1'b1; break; end
      end
      if (!ok) begin
        chk("valid_timeout", 0, 1);
        return;
      end
      $display("[TB] word idx=%0d data=0x%08h last=%0b sel=%0d t=%0d",
               m_if.out_idx, m_if.out_data, m_if.out_last, reg_sel, cyc - k);
      chk("word_idx",  32'(m_if.out_idx), 32'(vecs[i].idx));
      chk("word_data", m_if.out_data, vecs[i].data);
      chk("word_last", 32'(m_if.out_last), 32'(vecs[i].last));
      chk("word_sel",  32'(reg_sel), 32'(vecs[i].sel));
      if (i == abort_word) begin
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        chk_zero("abort");
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done_cnt - done0), 0);
        chk("abort_idle", 32'(busy), 0);
        return;
      end
      if (i == stall_word) begin
        m_if.out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(posedge clk); #1;
          chk("stall_valid", 32'(m_if.out_valid), 1);
          chk("stall_data",  m_if.out_data, vecs[i].data);
          chk("stall_idx",   32'(m_if.out_idx), 32'(vecs[i].idx));
          chk("stall_sel",   32'(reg_sel), 32'(vecs[i].sel));
        end
        m_if.out_ready = 1'b1;
      end
      if (i == poke_word) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (timing) chk("accept_edge", 32'(cyc - k), 32'(2 + 2 * i));
    end
    chk("done_pulse", 32'(done), 1);
    chk("done_busy", 32'(busy), 1);
    @(posedge clk); #1;
    chk("done_fall", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_valid", 32'(m_if.out_valid), 0);
    chk("done_count", 32'(done_cnt - done0), 1);
  endtask

  task automatic run_small();
    int k;
    bit ok;
    logic [31:0] exp_d;
    s_if.out_ready = 1'b1;
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    k = cyc;
    for (int i = 0; i < N_SMALL; i++) begin
      ok = 1'b0;
      for (int w = 0; w < 20; w++) begin
        @(posedge clk); #1;
        if (s_if.out_valid) begin ok = 1'b1; break; end
      end
      if (!ok) begin
        chk("s_valid_timeout", 0, 1);
        return;
      end
      exp_d = (i == 0) ? 32'h0 : (i < 4) ? 32'h200 + 32'(i) : csr_exp(i - 4);
      $display("[TB] slow word idx=%0d data=0x%08h last=%0b t=%0d",
               s_if.out_idx, s_if.out_data, s_if.out_last, cyc - k);
      chk("s_valid_edge", 32'(cyc - k), 32'(3 + 4 * i));
      chk("s_data", s_if.out_data, exp_d);
      chk("s_idx",  32'(s_if.out_idx), 32'(i));
      chk("s_last", 32'(s_if.out_last), 32'(i == N_SMALL - 1));
      chk("s_sel",  32'(reg_sel3), (i < 4) ? 32'(i) : 32'd3);
      @(posedge clk); #1;
    end
    chk("s_done", 32'(done3), 1);
    @(posedge clk); #1;
    chk("s_done_fall", 32'(done3), 0);
  endtask

  initial begin
    for (int i = 0; i < N_MAIN; i++) begin
      vecs[i].idx  = 6'(i);
      vecs[i].data = (i == 0) ? 32'h0 : (i < 32) ? 32'h100 + 32'(i) : csr_exp(i - 32);
      vecs[i].last = (i == N_MAIN - 1);
      vecs[i].sel  = (i < 32) ? 5'(i) : 5'd31;
    end
    rstn = 1'b0;
    start = 1'b0;
    start3 = 1'b0;
    m_if.out_ready = 1'b0;
    s_if.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    chk("reset_valid3", 32'(s_if.out_valid), 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    run_dump(-1, -1, -1, 1'b1);
    run_dump(7, 10, -1, 1'b0);
    run_dump(-1, -1, 15, 1'b0);
    run_dump(-1, -1, -1, 1'b1);

    run_small();
    run_small();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
